// File: rtl/fft_bitrev_reorder.sv
// Collects one bit-reversed FFT frame and replays it in natural bin order over valid/ready.
// Define FFT_REORDER_DROP_CNT_EN to add a saturating drop_cnt output counting overflow pulses.
module fft_bitrev_reorder #(
  parameter int NFFT = 64,
  parameter int DW   = 16,
  localparam int AW  = $clog2(NFFT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          busy,
  output logic          overflow
`ifdef FFT_REORDER_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

  localparam logic [AW:0]   WR_ONE  = 1;
  localparam logic [AW:0]   WR_FULL = NFFT;
  localparam logic [AW-1:0] RD_ONE  = 1;
  localparam logic [AW-1:0] RD_LAST = NFFT - 1;

  state_e          state_q, state_d;
  logic [AW:0]     wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_re_q, out_re_d;
  logic [DW-1:0]   out_im_q, out_im_d;
  logic [AW-1:0]   out_index_q, out_index_d;
  logic            out_last_q, out_last_d;
  logic [2*DW-1:0] mem_q [NFFT];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic            frame_full;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // A full write counter holds FILL for one extra cycle, so DRAIN starts one edge after the last write.
  assign frame_full = (wr_cnt_q == WR_FULL);
  assign overflow   = in_valid && ((state_q == DRAIN) || ((state_q == FILL) && frame_full));
  assign busy       = (state_q != IDLE);

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= {in_re, in_im};
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_first) begin
          mem_we   = 1'b1;
          wr_cnt_d = WR_ONE;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (frame_full) begin
          state_d  = DRAIN;
          rd_cnt_d = '0;
        end else if (in_valid) begin
          mem_we = 1'b1;
          if (in_first) begin
            wr_cnt_d = WR_ONE;
          end else begin
            mem_waddr = bitrev(wr_cnt_q[AW-1:0]);
            wr_cnt_d  = wr_cnt_q + WR_ONE;
          end
        end
      end
      DRAIN: begin
        // Once the last bin is loaded nothing more is fetched; only its handshake ends the frame.
        if (out_valid_q && out_last_q) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            wr_cnt_d    = '0;
            state_d     = IDLE;
          end
        end else if (!out_valid_q || out_ready) begin
          out_valid_d          = 1'b1;
          {out_re_d, out_im_d} = mem_q[rd_cnt_q];
          out_index_d          = rd_cnt_q;
          out_last_d           = (rd_cnt_q == RD_LAST);
          rd_cnt_d             = rd_cnt_q + RD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FFT_REORDER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else if (overflow && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: expected natural-order bins are queued per frame
// and compared against the DUT output every cycle out_valid is high.
module tb_fft_bitrev_reorder;
  localparam int NFFT = 64;
  localparam int DW   = 16;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, in_first;
  logic [DW-1:0] in_re, in_im;
  logic          out_valid, out_ready, out_last, busy, overflow;
  logic [DW-1:0] out_re, out_im;
  logic [AW-1:0] out_index;
`ifdef FFT_REORDER_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   ovfCount = 0;
  int   cyc = 0;
  bit   monitorOn = 1'b0;
  bit   bpEnable = 1'b0;

  fft_bitrev_reorder #(.NFFT(NFFT), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_first(in_first),
    .in_re(in_re),
    .in_im(in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re(out_re),
    .out_im(out_im),
    .out_index(out_index),
    .out_last(out_last),
    .busy(busy),
    .overflow(overflow)
`ifdef FFT_REORDER_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [AW-1:0] bitRev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) r = {r[AW-2:0], a[i]};
    return r;
  endfunction

  // Drives count samples (in_first on the first), gap idle cycles after each; a complete frame queues its natural-order bins.
  task automatic applyStimulus(input int count, input int gap, input bit patterned);
    logic [DW-1:0] natRe[NFFT];
    logic [DW-1:0] natIm[NFFT];
    logic [DW-1:0] re, im;
    logic [AW-1:0] pos;
    exp_t e;
    for (int k = 0; k < count; k++) begin
      pos = k[AW-1:0];
      if (patterned) begin
        re = {{(DW-AW){1'b0}}, bitRev(pos)};
        im = -re;
      end else begin
        re = DW'($urandom);
        im = DW'($urandom);
      end
      natRe[bitRev(pos)] = re;
      natIm[bitRev(pos)] = im;
      in_valid = 1'b1;
      in_first = (k == 0);
      in_re    = re;
      in_im    = im;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      checkOutput("busyFill", busy, 1);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    if (count == NFFT) begin
      for (int n = 0; n < NFFT; n++) begin
        e.idx  = n[AW-1:0];
        e.re   = natRe[n];
        e.im   = natIm[n];
        e.last = (n == NFFT - 1);
        expQ.push_back(e);
      end
    end
  endtask

  task automatic waitDrain();
    int i;
    i = 0;
    while ((expQ.size() != 0 || out_valid) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    checkOutput("drainDone", (expQ.size() == 0 && !out_valid), 1);
    checkOutput("busyIdle", busy, 0);
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = bpEnable ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    cyc++;
  end

  // Every valid cycle must show the queue head, so stalled samples are also checked for stability.
  always @(negedge clk) begin
    if (overflow) ovfCount++;
    if (monitorOn && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousValid", 1, 0);
      end else begin
        checkOutput("outIndex", out_index, expQ[0].idx);
        checkOutput("outRe", out_re, expQ[0].re);
        checkOutput("outIm", out_im, expQ[0].im);
        checkOutput("outLast", out_last, expQ[0].last);
        checkOutput("busyDrain", busy, 1);
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    int ovfBase;
    int i;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstLast", out_last, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstOvf", overflow, 0);
    checkOutput("rstIndex", out_index, 0);
    checkOutput("rstRe", out_re, 0);
    checkOutput("rstIm", out_im, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Samples without in_first in IDLE are discarded silently.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_re    = 16'h1234;
      #1;
      checkOutput("idleOvf", overflow, 0);
      @(posedge clk); #1;
      checkOutput("idleBusy", busy, 0);
    end
    in_valid  = 1'b0;
    monitorOn = 1'b1;

    $display("[TB] basic frame");
    applyStimulus(NFFT, 0, 1'b1);
    checkOutput("lat0", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("lat1", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("lat2", out_valid, 1);
    checkOutput("lat2Index", out_index, 0);
    waitDrain();
    checkOutput("basicOvf", ovfCount, 0);

    $display("[TB] backpressure");
    bpEnable = 1'b1;
    applyStimulus(NFFT, 0, 1'b1);
    waitDrain();
    bpEnable = 1'b0;

    $display("[TB] resync");
    ovfBase = ovfCount;
    applyStimulus(20, 0, 1'b0);
    applyStimulus(NFFT, 0, 1'b0);
    waitDrain();
    checkOutput("resyncOvf", ovfCount - ovfBase, 0);

    $display("[TB] overflow");
    ovfBase = ovfCount;
    applyStimulus(NFFT, 0, 1'b0);
    i = 0;
    while (!out_valid && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    checkOutput("ovfDrainSeen", out_valid, 1);
    for (int p = 0; p < 5; p++) begin
      in_valid = 1'b1;
      in_first = p[0];
      in_re    = 16'hDEAD;
      in_im    = 16'hBEEF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      @(posedge clk); #1;
    end
    waitDrain();
    checkOutput("ovfPulses", ovfCount - ovfBase, 5);
`ifdef FFT_REORDER_DROP_CNT_EN
    checkOutput("dropCnt", drop_cnt, 5);
`endif

    $display("[TB] reset mid-drain");
    applyStimulus(NFFT, 0, 1'b0);
    i = 0;
    while (!(out_valid && out_index == 6'd30) && i < 200) begin
      @(negedge clk);
      i++;
    end
    checkOutput("reachBin30", out_index, 30);
    #2;
    monitorOn = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("arstValid", out_valid, 0);
    checkOutput("arstBusy", busy, 0);
    checkOutput("arstLast", out_last, 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("postRstValid", out_valid, 0);
    monitorOn = 1'b1;
    applyStimulus(NFFT, 0, 1'b0);
    waitDrain();

    $display("[TB] gapped input");
    applyStimulus(NFFT, 2, 1'b0);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
